// File: rtl/sound_gen_pkg.sv
// Shared frame format and SPI master state type for the sound generator
// register write path (spi_cmd_master on the host side, spi_decoder on the
// device side).
package sound_gen_pkg;

  localparam int SPI_FRAME_BITS = 24;
  localparam int SPI_ADDR_W     = 5;
  localparam int SPI_DATA_W     = 16;
  localparam logic [2:0] SPI_WRITE_OP = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_BIT_LO = 3'd2,
    ST_BIT_HI = 3'd3,
    ST_HOLD   = 3'd4,
    ST_GAP    = 3'd5
  } spi_state_t;

  // Build the 24-bit write command: op/address byte, then data MSB first.
  function automatic logic [SPI_FRAME_BITS-1:0] spi_pack_cmd(
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    return {SPI_WRITE_OP, addr, data};
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Phase timer shared by every timed SPI phase. Counts 0..HALF_PERIOD-1 while
// running and pulses expire_out on the last cycle of each phase, wrapping to
// zero so the next phase starts with a fresh count.
module spi_phase_timer #(
  parameter int HALF_PERIOD = 10
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic start_in,
  input  logic run_in,
  output logic expire_out
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(HALF_PERIOD - 1);

  logic [CW-1:0] cnt_q;

  assign expire_out = run_in && (cnt_q == TERM);

  // Phase counter: cleared on start and at every phase boundary.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      cnt_q <= '0;
    end else if (start_in || expire_out) begin
      cnt_q <= '0;
    end else if (run_in) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_master.sv
// SPI mode-0 initiator: sends one 3-byte register write per accepted request.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | ready for a request, CS high
// ST_SETUP  | CS low, SCLK low, MOSI low before the first bit
// ST_BIT_LO | SCLK low, MOSI presents the current bit
// ST_BIT_HI | SCLK high, MOSI held; shift on exit
// ST_HOLD   | CS low after the last falling SCLK edge
// ST_GAP    | CS high, minimum spacing before the next frame
module spi_cmd_master
  import sound_gen_pkg::*;
#(
  parameter int HALF_PERIOD = 10,
  parameter int FRAME_BITS  = SPI_FRAME_BITS
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic [SPI_ADDR_W-1:0] addr_in,
  input  logic [SPI_DATA_W-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  spi_sclk_out,
  output logic                  spi_cs_out,
  output logic                  spi_mosi_out
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

  spi_state_t                state_q, state_d;
  logic [SPI_FRAME_BITS-1:0] shift_q, shift_d;
  logic [4:0]                bit_cnt_q, bit_cnt_d;
  logic                      accept;
  logic                      phase_done;
  logic                      timer_run;

  logic ready_d, busy_d, done_d, sclk_d, cs_d, mosi_d;

  assign timer_run = (state_q != ST_IDLE);

  spi_phase_timer #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_timer (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .start_in   (accept),
    .run_in     (timer_run),
    .expire_out (phase_done)
  );

  // State, shift register and bit counter.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // Next state, shifting and the registered-output targets.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    accept    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_in && ready_out) begin
          accept    = 1'b1;
          shift_d   = spi_pack_cmd(addr_in, data_in);
          bit_cnt_d = '0;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_done) state_d = ST_BIT_LO;
      end
      ST_BIT_LO: begin
        if (phase_done) state_d = ST_BIT_HI;
      end
      ST_BIT_HI: begin
        if (phase_done) begin
          shift_d   = {shift_q[SPI_FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          state_d   = (bit_cnt_q == LAST_BIT) ? ST_HOLD : ST_BIT_LO;
        end
      end
      ST_HOLD: begin
        if (phase_done) begin
          state_d = ST_GAP;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (phase_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // MOSI only changes when entering BIT_LO (SCLK low); it is held through
    // BIT_HI and HOLD so the last bit stays valid after its rising edge.
    case (state_d)
      ST_BIT_LO:         mosi_d = shift_d[SPI_FRAME_BITS-1];
      ST_BIT_HI, ST_HOLD: mosi_d = spi_mosi_out;
      default:           mosi_d = 1'b0;
    endcase

    sclk_d  = (state_d == ST_BIT_HI);
    cs_d    = (state_d == ST_IDLE) || (state_d == ST_GAP);
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // Registered outputs, all derived from the next state.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      ready_out    <= 1'b1;
      busy_out     <= 1'b0;
      done_out     <= 1'b0;
      spi_sclk_out <= 1'b0;
      spi_cs_out   <= 1'b1;
      spi_mosi_out <= 1'b0;
    end else begin
      ready_out    <= ready_d;
      busy_out     <= busy_d;
      done_out     <= done_d;
      spi_sclk_out <= sclk_d;
      spi_cs_out   <= cs_d;
      spi_mosi_out <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Bench for spi_cmd_master: two instances (HALF_PERIOD 10 and 1) checked
// every cycle against a frame-timeline model, plus a serial receiver that
// rebuilds each frame from SCLK/MOSI.
module tb_spi_cmd_master;

  localparam int HP0 = 10;
  localparam int HP1 = 1;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] valid_r = 2'b00;
  logic [4:0] addr_r [2];
  logic [15:0] data_r [2];

  logic [1:0] ready_w, busy_w, done_w, sclk_w, cs_w, mosi_w;

  int total = 0;
  int bad   = 0;

  always #5 clk_in = ~clk_in;

  spi_cmd_master #(.HALF_PERIOD(HP0)) u0 (
    .clk_in(clk_in), .reset_n_in(rst_n), .addr_in(addr_r[0]), .data_in(data_r[0]),
    .valid_in(valid_r[0]), .ready_out(ready_w[0]), .busy_out(busy_w[0]),
    .done_out(done_w[0]), .spi_sclk_out(sclk_w[0]), .spi_cs_out(cs_w[0]),
    .spi_mosi_out(mosi_w[0])
  );

  spi_cmd_master #(.HALF_PERIOD(HP1)) u1 (
    .clk_in(clk_in), .reset_n_in(rst_n), .addr_in(addr_r[1]), .data_in(data_r[1]),
    .valid_in(valid_r[1]), .ready_out(ready_w[1]), .busy_out(busy_w[1]),
    .done_out(done_w[1]), .spi_sclk_out(sclk_w[1]), .spi_cs_out(cs_w[1]),
    .spi_mosi_out(mosi_w[1])
  );

  function automatic int hpv(int i);
    return (i == 0) ? HP0 : HP1;
  endfunction

  // Expected {ready,busy,done,sclk,cs,mosi} at cycle k after the accept edge.
  // A frame is: hp setup, 24 x (hp low + hp high), hp hold, then hp gap with
  // CS high (done on its first cycle), then idle.
  function automatic logic [5:0] exp_out(int hp, bit a, int k, logic [23:0] f);
    logic r, b, d, s, c, m;
    int off;
    r = 1'b1; b = 1'b0; d = 1'b0; s = 1'b0; c = 1'b1; m = 1'b0;
    if (a) begin
      r = 1'b0;
      b = 1'b1;
      c = (k >= 50 * hp);
      d = (k == 50 * hp);
      if (k >= hp && k < 49 * hp) begin
        off = k - hp;
        s = ((off % (2 * hp)) >= hp);
        m = f[5'(23 - off / (2 * hp))];
      end else if (k >= 49 * hp && k < 50 * hp) begin
        m = f[0];
      end
    end
    return {r, b, d, s, c, m};
  endfunction

  // Model state
  bit          act [2];
  int          k [2];
  logic [23:0] fr [2];
  int          acc_cnt [2];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  // Receiver / measurement state
  int          cyc = 0;
  int          rxn [2];
  logic [23:0] rxsh [2];
  logic [23:0] last_rx [2];
  logic [23:0] prev_rx [2];
  int          low_run [2], high_run [2], last_low [2], last_high [2];
  int          rises [2], last_rises [2], last_rise_cyc [2];
  int          pmin [2], pmax [2], last_pmin [2], last_pmax [2];
  int          frames [2], partial [2], done_cnt [2];
  logic        pcs [2], psclk [2];

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got 0x%0h (%0d) want 0x%0h (%0d)", name, got, got, want, want);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timeout got 0 want 1", name);
  endtask

  // Model: tracks accepts from the requester's inputs and the cycle offset.
  initial begin
    for (int i = 0; i < 2; i++) begin
      act[i] = 1'b0; k[i] = 0; fr[i] = '0; acc_cnt[i] = 0;
    end
    forever begin
      @(posedge clk_in or negedge rst_n);
      if (!rst_n) begin
        for (int i = 0; i < 2; i++) begin
          if (act[i] && k[i] < 50 * hpv(i)) begin
            if (i == 0) void'(q0.pop_back());
            else        void'(q1.pop_back());
          end
          act[i] = 1'b0;
          k[i]   = 0;
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          if (act[i]) begin
            k[i]++;
            if (k[i] == 51 * hpv(i)) act[i] = 1'b0;
          end else if (valid_r[i]) begin
            act[i] = 1'b1;
            k[i]   = 0;
            fr[i]  = {3'b000, addr_r[i], data_r[i]};
            if (i == 0) q0.push_back(fr[i]);
            else        q1.push_back(fr[i]);
            acc_cnt[i]++;
          end
        end
      end
    end
  end

  // Per-cycle compare plus serial receive and timing measurement.
  initial begin
    logic [5:0]  got, want;
    logic [23:0] expf;
    for (int i = 0; i < 2; i++) begin
      rxn[i] = 0; rxsh[i] = '0; last_rx[i] = '0; prev_rx[i] = '0;
      low_run[i] = 0; high_run[i] = 0; last_low[i] = 0; last_high[i] = 0;
      rises[i] = 0; last_rises[i] = 0; last_rise_cyc[i] = 0;
      pmin[i] = 0; pmax[i] = 0; last_pmin[i] = 0; last_pmax[i] = 0;
      frames[i] = 0; partial[i] = 0; done_cnt[i] = 0;
      pcs[i] = 1'b1; psclk[i] = 1'b0;
    end
    forever begin
      @(negedge clk_in);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        got  = {ready_w[i], busy_w[i], done_w[i], sclk_w[i], cs_w[i], mosi_w[i]};
        want = exp_out(hpv(i), act[i], k[i], fr[i]);
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL cycle_outputs inst%0d cyc=%0d k=%0d: got rbdsCm=%b want %b",
                   i, cyc, k[i], got, want);
        end
        if (done_w[i]) done_cnt[i]++;
        if (!cs_w[i]) begin
          if (pcs[i]) begin
            last_high[i] = high_run[i];
            high_run[i] = 0; low_run[i] = 0; rises[i] = 0; rxn[i] = 0;
            pmin[i] = 1000000; pmax[i] = 0;
          end
          low_run[i]++;
          if (sclk_w[i] && !psclk[i]) begin
            if (rises[i] > 0) begin
              if (cyc - last_rise_cyc[i] < pmin[i]) pmin[i] = cyc - last_rise_cyc[i];
              if (cyc - last_rise_cyc[i] > pmax[i]) pmax[i] = cyc - last_rise_cyc[i];
            end
            last_rise_cyc[i] = cyc;
            rises[i]++;
            rxsh[i] = {rxsh[i][22:0], mosi_w[i]};
            rxn[i]++;
          end
        end else begin
          if (!pcs[i]) begin
            last_low[i] = low_run[i];
            last_rises[i] = rises[i];
            last_pmin[i] = pmin[i];
            last_pmax[i] = pmax[i];
            if (rxn[i] == 24) begin
              if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                total++; bad++;
                $display("FAIL frame_order inst%0d: got frame 0x%06h want none", i, rxsh[i]);
              end else begin
                expf = (i == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("frame_order inst%0d", i), int'(rxsh[i]), int'(expf));
              end
              prev_rx[i] = last_rx[i];
              last_rx[i] = rxsh[i];
              frames[i]++;
            end else if (rxn[i] > 0) begin
              partial[i]++;
            end
            rxn[i] = 0;
          end
          high_run[i]++;
        end
        pcs[i] = cs_w[i];
        psclk[i] = sclk_w[i];
      end
    end
  end

  task automatic send(input int i, input logic [4:0] a, input logic [15:0] d, input bit hold);
    int n0;
    @(posedge clk_in); #2;
    valid_r[i] = 1'b1; addr_r[i] = a; data_r[i] = d;
    n0 = acc_cnt[i];
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk_in); #1;
      if (acc_cnt[i] > n0) begin
        #1;
        if (!hold) valid_r[i] = 1'b0;
        return;
      end
    end
    timeout_fail($sformatf("accept inst%0d", i));
  endtask

  task automatic wait_idle(input int i);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk_in);
      if (!act[i]) return;
    end
    timeout_fail($sformatf("frame_end inst%0d", i));
  endtask

  initial begin
    int f0, d0;
    addr_r[0] = '0; addr_r[1] = '0; data_r[0] = '0; data_r[1] = '0;
    repeat (3) @(negedge clk_in);
    check("reset ready", int'(ready_w[0]), 1);
    check("reset cs",    int'(cs_w[0]), 1);
    check("reset sclk",  int'(sclk_w[0]), 0);
    check("reset busy",  int'(busy_w[1]), 0);
    @(posedge clk_in); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk_in);

    // Basic frame at HALF_PERIOD=10
    send(0, 5'h01, 16'h8765, 1'b0);
    wait_idle(0);
    check("basic rx",    int'(last_rx[0]), 24'h018765);
    check("basic cs_low", last_low[0], 500);
    check("basic rises", last_rises[0], 24);
    check("basic sclk_period", last_pmax[0], 20);
    check("basic done",  done_cnt[0], 1);

    // Boundary data
    send(0, 5'h1F, 16'hFFFF, 1'b0);
    wait_idle(0);
    check("ones rx", int'(last_rx[0]), 24'h1FFFFF);
    send(0, 5'h00, 16'h0000, 1'b0);
    wait_idle(0);
    check("zeros rx", int'(last_rx[0]), 24'h000000);

    // Back-to-back with valid held high
    send(0, 5'd3, 16'h1234, 1'b1);
    send(0, 5'd4, 16'hABCD, 1'b0);
    wait_idle(0);
    wait_idle(0);
    check("b2b first",  int'(prev_rx[0]), 24'h031234);
    check("b2b second", int'(last_rx[0]), 24'h04ABCD);
    check("b2b cs_high_gap", last_high[0], HP0 + 1);

    // Input changes and valid toggles mid-frame are ignored
    f0 = frames[0];
    send(0, 5'd7, 16'h1357, 1'b0);
    repeat (100) @(posedge clk_in);
    #2;
    for (int n = 0; n < 6; n++) begin
      valid_r[0] = n[0];
      addr_r[0]  = 5'($urandom);
      data_r[0]  = 16'($urandom);
      @(posedge clk_in); #2;
    end
    valid_r[0] = 1'b0;
    wait_idle(0);
    repeat (30) @(negedge clk_in);
    check("handshake rx", int'(last_rx[0]), 24'h071357);
    check("handshake frames", frames[0] - f0, 1);

    // Reset mid-frame after 11 bits
    d0 = done_cnt[0];
    send(0, 5'd9, 16'h2468, 1'b0);
    begin : wait_bits
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk_in);
        if (rxn[0] >= 11) disable wait_bits;
      end
      timeout_fail("bit11");
    end
    @(posedge clk_in); #1 rst_n = 1'b0;
    #1;
    check("midreset cs",   int'(cs_w[0]), 1);
    check("midreset sclk", int'(sclk_w[0]), 0);
    repeat (4) @(negedge clk_in);
    check("midreset no_done", done_cnt[0] - d0, 0);
    check("midreset partial", partial[0], 1);
    @(posedge clk_in); #2 rst_n = 1'b1;
    send(0, 5'h15, 16'h0F0F, 1'b0);
    wait_idle(0);
    check("post_reset rx", int'(last_rx[0]), 24'h150F0F);

    // HALF_PERIOD=1 instance
    send(1, 5'd2, 16'hA5C3, 1'b0);
    wait_idle(1);
    check("hp1 rx",     int'(last_rx[1]), 24'h02A5C3);
    check("hp1 cs_low", last_low[1], 50);
    check("hp1 rises",  last_rises[1], 24);
    check("hp1 period_min", last_pmin[1], 2);
    check("hp1 period_max", last_pmax[1], 2);

    // Randomized traffic on both instances
    for (int n = 0; n < 15000; n++) begin
      @(posedge clk_in); #2;
      for (int i = 0; i < 2; i++) begin
        valid_r[i] = ($urandom_range(0, 3) == 0);
        addr_r[i]  = 5'($urandom);
        data_r[i]  = 16'($urandom);
      end
    end
    valid_r = 2'b00;
    wait_idle(0);
    wait_idle(1);
    repeat (5) @(negedge clk_in);
    check("queue drained inst0", q0.size(), 0);
    check("queue drained inst1", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
